// File: rtl/bus_select_encoder_if.sv
// rtl/bus_select_encoder_if.sv - bus-source strobe / select-code interface
//
// Purpose: carries the source strobes and hold from the control unit to the
// select encoder, and the registered select code and debug flags back out.
//
// Signals:
//   src_out    strobe per source, bit i = source i wants the bus
//   hold       freeze the encoder's registered state for this cycle
//   sel        registered select code of the granted source
//   sel_valid  registered, at least one strobe was seen
//   multi_err  registered, more than one strobe was seen
//   err_count  saturating count of multi-hot cycles
//
// Modports: master = control-unit side, slave = encoder side.
interface bus_select_encoder_if #(
   parameter int NUM_SRC = 24,
   parameter int SEL_W   = 5,
   parameter int ERR_W   = 8
);
   logic [NUM_SRC-1:0] src_out;
   logic               hold;
   logic [SEL_W-1:0]   sel;
   logic               sel_valid;
   logic               multi_err;
   logic [ERR_W-1:0]   err_count;

   modport master (
      output src_out,
      output hold,
      input  sel,
      input  sel_valid,
      input  multi_err,
      input  err_count
   );

   modport slave (
      input  src_out,
      input  hold,
      output sel,
      output sel_valid,
      output multi_err,
      output err_count
   );
endinterface

// File: rtl/bus_select_encoder.sv
// rtl/bus_select_encoder.sv - registered bus-source select encoder with arbitration
//
// Purpose: turns the per-source "drive bus" strobes into a registered mux
// select code. Multi-hot requests are resolved by fixed priority (lowest
// index) or round-robin, flagged on multi_err and counted in err_count.
//
// Ports:
//   clock  system clock, all state updates on the rising edge
//   clear  synchronous active-high reset, beats hold and src_out
//   bus    bus_select_encoder_if.slave: src_out/hold in,
//          sel/sel_valid/multi_err/err_count out (all registered)
module bus_select_encoder #(
   parameter int NUM_SRC = 24,
   parameter int SEL_W   = 5,
   parameter int RR_MODE = 0,
   parameter int ERR_W   = 8
) (
   input logic                 clock,
   input logic                 clear,
   bus_select_encoder_if.slave bus
);

   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] upper_req;
   logic [SEL_W-1:0]   rr_ptr;
   logic               any_req;
   logic               multi_req;
   logic [SEL_W-1:0]   grant_low;
   logic [SEL_W-1:0]   grant_up;
   logic [SEL_W-1:0]   grant;
   logic [SEL_W-1:0]   next_ptr;

   function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
      logic [SEL_W-1:0] r;
      r = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (v[i]) r = SEL_W'(i);
      end
      return r;
   endfunction

   assign req     = bus.src_out;
   assign any_req = |req;
   // clearing the lowest set bit leaves something only if two or more were set
   assign multi_req = |(req & (req - NUM_SRC'(1)));

   // Round-robin: requests at or above the pointer take precedence; if there
   // are none the scan has wrapped, so the lowest request overall wins.
   always_comb begin
      upper_req = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         upper_req[i] = req[i] && (SEL_W'(i) >= rr_ptr);
      end
   end

   assign grant_low = lowest_set(req);
   assign grant_up  = lowest_set(upper_req);
   assign grant     = ((RR_MODE != 0) && (|upper_req)) ? grant_up : grant_low;

   // pointer wraps at NUM_SRC, not at the code width
   assign next_ptr = (grant == SEL_W'(NUM_SRC - 1)) ? '0 : grant + SEL_W'(1);

   always_ff @(posedge clock) begin
      if (clear) begin
         bus.sel       <= '0;
         bus.sel_valid <= 1'b0;
         bus.multi_err <= 1'b0;
         bus.err_count <= '0;
         rr_ptr        <= '0;
      end else if (!bus.hold) begin
         bus.sel_valid <= any_req;
         bus.multi_err <= multi_req;
         if (any_req) begin
            bus.sel <= grant;
            if (RR_MODE != 0) rr_ptr <= next_ptr;
         end
         if (multi_req && !(&bus.err_count)) begin
            bus.err_count <= bus.err_count + ERR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bus_select_encoder.sv
// tb/tb_bus_select_encoder.sv - scoreboard bench for bus_select_encoder
//
// Purpose: drives three encoder instances (fixed priority, round-robin, and
// round-robin with a 2-bit error counter) with identical stimulus and checks
// every registered output against a reference model one cycle later.
//
// Ports: none (top-level bench).
module tb_bus_select_encoder;
   localparam int N = 24;

   logic clock = 1'b0;
   logic clear;
   always #5 clock = ~clock;

   bus_select_encoder_if #(.NUM_SRC(N), .SEL_W(5), .ERR_W(8)) if0 ();
   bus_select_encoder_if #(.NUM_SRC(N), .SEL_W(5), .ERR_W(8)) if1 ();
   bus_select_encoder_if #(.NUM_SRC(N), .SEL_W(5), .ERR_W(2)) if2 ();

   bus_select_encoder #(.NUM_SRC(N), .SEL_W(5), .RR_MODE(0), .ERR_W(8)) dut0 (
      .clock(clock), .clear(clear), .bus(if0.slave));
   bus_select_encoder #(.NUM_SRC(N), .SEL_W(5), .RR_MODE(1), .ERR_W(8)) dut1 (
      .clock(clock), .clear(clear), .bus(if1.slave));
   bus_select_encoder #(.NUM_SRC(N), .SEL_W(5), .RR_MODE(1), .ERR_W(2)) dut2 (
      .clock(clock), .clear(clear), .bus(if2.slave));

   typedef struct packed {
      logic [2:0][4:0] sel;
      logic [2:0]      valid;
      logic [2:0]      err;
      logic [2:0][7:0] cnt;
   } exp_t;

   exp_t q[$];

   // reference state per instance
   int m_sel [3];
   int m_cnt [3];
   int m_ptr [3];
   bit m_valid [3];
   bit m_err [3];
   int rr [3]   = '{0, 1, 1};
   int cmax [3] = '{255, 255, 3};

   int total  = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_sel[d] = 0; m_cnt[d] = 0; m_ptr[d] = 0; m_valid[d] = 0; m_err[d] = 0;
      end
   endtask

   // Apply one cycle of stimulus and push what the outputs must show after
   // the next rising edge.
   task automatic drive(input logic [N-1:0] s, input logic h, input logic c);
      exp_t e;
      int   n;
      int   g;
      int   idx;
      @(negedge clock);
      clear       = c;
      if0.src_out = s; if1.src_out = s; if2.src_out = s;
      if0.hold    = h; if1.hold    = h; if2.hold    = h;
      if (c) model_reset();
      else if (!h) begin
         n = $countones(s);
         for (int d = 0; d < 3; d++) begin
            if (n == 0) begin
               m_valid[d] = 0;
               m_err[d]   = 0;
            end else begin
               g = -1;
               for (int k = 0; k < N; k++) begin
                  idx = ((rr[d] != 0 ? m_ptr[d] : 0) + k) % N;
                  if (g < 0 && s[idx]) g = idx;
               end
               m_sel[d]   = g;
               m_valid[d] = 1;
               m_err[d]   = (n > 1);
               if (n > 1 && m_cnt[d] < cmax[d]) m_cnt[d]++;
               if (rr[d] != 0) m_ptr[d] = (g + 1) % N;
            end
         end
      end
      for (int d = 0; d < 3; d++) begin
         e.sel[d]   = 5'(m_sel[d]);
         e.valid[d] = m_valid[d];
         e.err[d]   = m_err[d];
         e.cnt[d]   = 8'(m_cnt[d]);
      end
      q.push_back(e);
   endtask

   function automatic logic [N-1:0] bit_of(input int i);
      return N'(1) << i;
   endfunction

   function automatic logic [N-1:0] rand_multi();
      int a;
      int b;
      a = $urandom_range(0, N - 2);
      b = $urandom_range(a + 1, N - 1);
      return (N'($urandom) & N'($urandom)) | bit_of(a) | bit_of(b);
   endfunction

   // monitor: registered outputs are presented every cycle
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("d0_sel",   32'(if0.sel),       32'(e.sel[0]));
            chk("d0_valid", 32'(if0.sel_valid), 32'(e.valid[0]));
            chk("d0_multi", 32'(if0.multi_err), 32'(e.err[0]));
            chk("d0_count", 32'(if0.err_count), 32'(e.cnt[0]));
            chk("d1_sel",   32'(if1.sel),       32'(e.sel[1]));
            chk("d1_valid", 32'(if1.sel_valid), 32'(e.valid[1]));
            chk("d1_multi", 32'(if1.multi_err), 32'(e.err[1]));
            chk("d1_count", 32'(if1.err_count), 32'(e.cnt[1]));
            chk("d2_sel",   32'(if2.sel),       32'(e.sel[2]));
            chk("d2_valid", 32'(if2.sel_valid), 32'(e.valid[2]));
            chk("d2_multi", 32'(if2.multi_err), 32'(e.err[2]));
            chk("d2_count", 32'(if2.err_count), 32'(e.cnt[2]));
         end
      end
   end

   initial begin
      logic [N-1:0] s;
      int r;
      clear = 1'b1;
      if0.src_out = '0; if1.src_out = '0; if2.src_out = '0;
      if0.hold = 1'b0;  if1.hold = 1'b0;  if2.hold = 1'b0;
      model_reset();

      // reset beats hold and an all-ones request
      drive('1, 1'b1, 1'b1);
      drive('1, 1'b1, 1'b1);

      // one-hot walk
      for (int i = 0; i < N; i++) drive(bit_of(i), 1'b0, 1'b0);

      // multi-hot then idle
      drive(bit_of(3) | bit_of(7) | bit_of(20), 1'b0, 1'b0);
      drive('0, 1'b0, 1'b0);

      // round-robin rotation from a fresh pointer, then wrap to bit 0
      drive('0, 1'b0, 1'b1);
      repeat (5) drive(bit_of(2) | bit_of(5) | bit_of(23), 1'b0, 1'b0);
      drive(bit_of(23), 1'b0, 1'b0);
      drive(bit_of(0), 1'b0, 1'b0);
      drive(bit_of(0) | bit_of(1), 1'b0, 1'b0);

      // hold freezes everything, release takes the new request
      drive(bit_of(9), 1'b0, 1'b0);
      repeat (3) drive(bit_of(4) | bit_of(11), 1'b1, 1'b0);
      drive(bit_of(4), 1'b0, 1'b0);

      // small-counter saturation
      repeat (5) drive(rand_multi(), 1'b0, 1'b0);

      // clear mid-stream with hold and all-ones, then multi-hot from index 0
      drive('1, 1'b1, 1'b1);
      repeat (3) drive(rand_multi(), 1'b0, 1'b0);

      // saturate the 8-bit counters
      repeat (300) drive(rand_multi(), $urandom_range(0, 15) == 0, 1'b0);

      // random mix
      repeat (400) begin
         r = $urandom_range(0, 3);
         if (r == 0) s = '0;
         else if (r == 1) s = bit_of($urandom_range(0, N - 1));
         else s = N'($urandom);
         drive(s, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      end
      drive('0, 1'b0, 1'b0);

      repeat (3) @(posedge clock);
      #2;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bus_select_encoder.md
Name: bus_select_encoder

Overview:
Parametrised, registered successor to the combinational bus-source encoder. Takes the per-source "drive bus" strobes (R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Cout, plus spares) and produces the registered bus-mux select code. Adds fixed-priority or round-robin resolution of multi-hot requests, a hold/freeze input, an error flag and a saturating error counter for debug. Sits between the control unit and the bus multiplexer.

Parameters:
NUM_SRC, 24, number of source strobes; legal range 2..32
SEL_W, 5, select code width; must satisfy 2**SEL_W >= NUM_SRC
RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin among asserted strobes
ERR_W, 8, width of the saturating multi-hot error counter

Ports:
clock  in  1  system clock; all state updates on rising edge
clear  in  1  reset; synchronous, active-high
src_out  in  NUM_SRC  source strobes; bit i = source i requests the bus; bit order matches current encoder codes (0 = R0 ... 23 = Cout)
hold  in  1  freeze: all registered state keeps its value this cycle
sel  out  SEL_W  registered select code of the granted source
sel_valid  out  1  registered; 1 = at least one strobe was asserted in the sampled cycle
multi_err  out  1  registered; 1 = more than one strobe was asserted in the sampled cycle
err_count  out  ERR_W  number of sampled multi-hot cycles, saturating at all-ones

Behaviour:
- Reset (clear=1 at a rising edge): sel=0, sel_valid=0, multi_err=0, err_count=0, round-robin pointer rr_ptr=0. clear has priority over hold and over src_out.
- Latency: exactly 1 cycle. src_out sampled at edge k appears on sel/sel_valid/multi_err after edge k; there is no combinational path from input to output.
- hold=1 (clear=0): sel, sel_valid, multi_err, err_count and rr_ptr all keep their values; src_out is ignored.
- No strobe asserted: sel keeps its previous value; sel_valid=0; multi_err=0; rr_ptr unchanged.
- Exactly one strobe i asserted: sel=i; sel_valid=1; multi_err=0. In RR_MODE=1, rr_ptr becomes (i+1) mod NUM_SRC.
- Multiple strobes asserted: multi_err=1; sel_valid=1; err_count increments by 1 unless already all-ones.
  - RR_MODE=0: sel = lowest asserted index.
  - RR_MODE=1: sel = first asserted index scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_SRC-1, 0, ...); then rr_ptr = (sel+1) mod NUM_SRC.
- In RR_MODE=0, rr_ptr is held at 0 and is unused.
- Wrap rule: the pointer and the scan wrap at NUM_SRC, not at 2**SEL_W. Codes NUM_SRC..2**SEL_W-1 are never output.
- err_count saturation: at all-ones, further multi-hot cycles leave it at all-ones; multi_err still pulses.
- clear asserted mid-operation: the next cycle shows reset values regardless of src_out or hold. The first sample is taken on the edge after clear deasserts.
- sel is zero-extended from the granted index to SEL_W bits.

Test Plan:
1. Default params: assert clear for 2 cycles, then one-hot walk src_out bit 0..23, one bit per cycle -> one cycle later sel=0..23 in order; sel_valid=1; multi_err=0; err_count=0.
2. RR_MODE=0: src_out bits 3, 7 and 20 set together -> sel=3, multi_err=1, err_count=1. Then src_out=0 -> sel stays 3, sel_valid=0, multi_err=0.
3. RR_MODE=1: hold bits 2, 5 and 23 set for 5 consecutive cycles -> sel sequence 2, 5, 23, 2, 5; err_count=5. With only bit 0 set after a grant of 23 -> sel=0, rr_ptr=1.
4. hold: grant sel=9, then hold=1 for 3 cycles while src_out=bit 4 -> sel=9 and err_count unchanged throughout. Release hold -> sel=4 one cycle later.
5. ERR_W=2: 5 consecutive multi-hot cycles -> err_count 1, 2, 3, 3, 3.
6. clear with hold=1 and src_out=all-ones mid-stream -> next cycle sel=0, sel_valid=0, multi_err=0, err_count=0. In RR_MODE=1 the next multi-hot grant starts scanning from index 0.
